// File: rtl/gate_unit_seq.sv
// ============================================================================
// Module   : gate_unit_seq
// Brief    : N-bit, 8-function two-operand logic unit with valid/ready
//            handshake; parallel (1 cycle) or bit-serial LSB-first evaluation.
//            Optional popcount output enabled by macro GATE_POPCOUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_unit_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             serial,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             busy
`ifdef GATE_POPCOUNT_EN
    ,
    output logic [CNT_W-1:0] ones
`endif
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_hold = 2'd2;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] f_gate(
        input logic [2:0]       fop,
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb
    );
        logic [WIDTH-1:0] res;
        case (fop)
            3'd0:    res = fa & fb;
            3'd1:    res = fa | fb;
            3'd2:    res = ~(fa & fb);
            3'd3:    res = ~(fa | fb);
            3'd4:    res = fa ^ fb;
            3'd5:    res = ~(fa ^ fb);
            3'd6:    res = ~fa & fb;
            default: res = fa & ~fb;
        endcase
        return res;
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] w_f_in;
    logic [WIDTH-1:0] w_f_lat;
    logic [WIDTH-1:0] w_mask;
    logic             w_accept;

    assign w_f_in   = f_gate(op, a, b);
    assign w_f_lat  = f_gate(r_op, r_a, r_b);
    assign w_accept = in_valid & in_ready;
    assign s        = r_s;

    // One-hot select of the bit position being evaluated in RUN
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask[i] = (r_cnt == CNT_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (in_valid) begin
                    w_next_state = serial ? c_run : c_hold;
                end
            end
            c_run: begin
                if (r_cnt == c_last) begin
                    w_next_state = c_hold;
                end
            end
            c_hold: begin
                if (out_ready) begin
                    w_next_state = c_idle;
                end
            end
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_idle);
        busy      = (r_state == c_run);
        out_valid = (r_state == c_hold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_cnt <= '0;
            r_s   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_op  <= op;
                        r_cnt <= '0;
                        r_s   <= serial ? '0 : w_f_in;
                    end
                end
                c_run: begin
                    // Unevaluated bits are still 0, so OR-ing in one bit is exact
                    r_s   <= r_s | (w_f_lat & w_mask);
                    r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_POPCOUNT_EN
    logic [CNT_W-1:0] r_ones;
    logic [CNT_W-1:0] w_pop_in;

    always_comb begin
        w_pop_in = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop_in = w_pop_in + {{(CNT_W-1){1'b0}}, w_f_in[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_ones <= serial ? '0 : w_pop_in;
                    end
                end
                c_run: begin
                    if (|(w_f_lat & w_mask)) begin
                        r_ones <= r_ones + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ones = r_ones;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_unit_seq.sv
// ============================================================================
// Module   : tb_gate_unit_seq
// Brief    : Directed self-checking bench for gate_unit_seq (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_unit_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       op = '0;
    logic             serial = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             busy;
`ifdef GATE_POPCOUNT_EN
    logic [CNT_W-1:0] ones;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    gate_unit_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .serial    (serial),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .busy      (busy)
`ifdef GATE_POPCOUNT_EN
        ,
        .ones      (ones)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one transaction from a negedge; returns at the negedge after acceptance
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top,
                        input logic tser);
        @(negedge clk);
        a = ta; b = tb_; op = top; serial = tser; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consume_in_ready", 32'(in_ready), 32'd1);
        chk("consume_out_valid", 32'(out_valid), 32'd0);
    endtask

    logic [7:0]  par_exp [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0C, 8'h30};
    logic [15:0] part_mask;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_s", 32'(s), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Parallel, all opcodes; result visible one cycle after acceptance
        for (int k = 0; k < 8; k++) begin
            send(8'hF0, 8'hCC, 3'(k), 1'b0);
            chk("par_out_valid", 32'(out_valid), 32'd1);
            chk("par_busy", 32'(busy), 32'd0);
            chk("par_s", 32'(s), 32'(par_exp[k]));
            consume();
        end

        // Serial XOR, LSB-first partial results
        send(8'hA5, 8'h0F, 3'd4, 1'b1);
        chk("ser_busy0", 32'(busy), 32'd1);
        chk("ser_s0", 32'(s), 32'h0);
        chk("ser_in_ready0", 32'(in_ready), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            part_mask = (16'h1 << k) - 16'h1;
            if (k < 8) begin
                chk("ser_busy", 32'(busy), 32'd1);
                chk("ser_out_valid_lo", 32'(out_valid), 32'd0);
                chk("ser_partial", 32'(s), 32'(8'hAA & part_mask[7:0]));
            end else begin
                chk("ser_out_valid", 32'(out_valid), 32'd1);
                chk("ser_busy_done", 32'(busy), 32'd0);
                chk("ser_s", 32'(s), 32'hAA);
            end
        end
        consume();

        // Backpressure in HOLD with a competing request pending
        send(8'h12, 8'h34, 3'd0, 1'b0);
        a = 8'hF0; b = 8'h0F; op = 3'd1; serial = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_s", 32'(s), 32'h10);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_handoff_in_ready", 32'(in_ready), 32'd1);
        chk("bp_handoff_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_out_valid", 32'(out_valid), 32'd1);
        chk("bp_next_s", 32'(s), 32'hFF);
        consume();

        // Operand changes during RUN must not leak into the result
        send(8'hFF, 8'h00, 3'd1, 1'b1);
        a = 8'h00; b = 8'hFF; op = 3'd0; serial = 1'b0;
        repeat (8) @(negedge clk);
        chk("chg_out_valid", 32'(out_valid), 32'd1);
        chk("chg_s", 32'(s), 32'hFF);
        consume();

        // Asynchronous reset in the middle of a serial run
        send(8'hA5, 8'h0F, 3'd4, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_s", 32'(s), 32'h0);
        chk("amid_out_valid", 32'(out_valid), 32'd0);
        chk("amid_in_ready", 32'(in_ready), 32'd1);
        chk("amid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

`ifdef GATE_POPCOUNT_EN
        send(8'hF0, 8'hCC, 3'd4, 1'b0);
        chk("pop_par_s", 32'(s), 32'h3C);
        chk("pop_par_ones", 32'(ones), 32'd4);
        consume();
        send(8'hF0, 8'hCC, 3'd4, 1'b1);
        chk("pop_ser_clear", 32'(ones), 32'd0);
        repeat (8) @(negedge clk);
        chk("pop_ser_valid", 32'(out_valid), 32'd1);
        chk("pop_ser_ones", 32'(ones), 32'd4);
        consume();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
